pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central hazard/control unit for the next-gen parametrised 5-stage pipeline (IF/ID/EX/MEM/WB).
//  Replaces separate hazard-detect and forwarding logic with one block: forwarding selects,
//  load-use bubbles, multi-cycle EX (multiply) stalls, branch flushes and an interrupt-entry FSM.
//  Sits beside the ID/EX/MEM/WB buffers; drives their stall/flush/bubble inputs and the PC select.
// PARAMETERS
//  RA_W      4   register address width (2**RA_W architectural regs)
//  MUL_LAT   4   EX cycles for a multiply (>=2); other ALU ops take 1
//  CNT_W     32  width of perf counters (used only with PIPE_PERF_CNT_EN)
// PORTS
//  clk            in   1      clock, rising edge
//  reset          in   1      synchronous, active-high
//  id_src/id_dst  in   RA_W   ID register addresses; id_src_used/id_dst_used in 1 each
//  id_is_mul      in   1      ID instruction is a multiply
//  ex_src/ex_dst  in   RA_W   EX operand addresses; ex_mem_read in 1; ex_reg_write in 1
//  mem_dst        in   RA_W   EX/MEM dest; mem_reg_write in 1
//  wb_dst         in   RA_W   MEM/WB dest; wb_reg_write in 1
//  branch_taken   in   1      EX resolved taken branch/jump
//  irq            in   1      level interrupt request
//  fwd_src,fwd_dst out 2      00 regfile, 01 EX/MEM result, 10 MEM/WB result
//  stall_if,stall_id out 1    hold PC / IF-ID buffer
//  bubble_ex      out  1      load zero control into ID/EX
//  flush_if_id,flush_id_ex out 1  squash buffers
//  irq_push_pc,irq_push_flags,irq_load_vec out 1  interrupt sequence strobes; irq_ack out 1
//  mul_busy       out  1      multiply in flight
//  perf_stalls,perf_flushes out CNT_W  event counters
// BEHAVIOUR
//  Reset: all outputs 0, fwd_* = 00, FSM IDLE, mul counter 0, irq_pending 0, counters 0.
//  Forwarding (comb): EX/MEM wins over MEM/WB on same addr; match needs *_reg_write=1.
//  Load-use (comb): ex_mem_read & ex_reg_write & ((id_src_used&id_src==ex_dst)|(id_dst_used&id_dst==ex_dst))
//   -> stall_if=stall_id=bubble_ex=1 for exactly one cycle.
//  Multiply: ID mul entering EX loads counter MUL_LAT-1; while counter!=0: mul_busy=1,
//   stall_if=stall_id=1, EX held, bubble_ex=0; counter decrements each cycle.
//  Branch: branch_taken -> flush_if_id=flush_id_ex=1 same cycle (2-cycle penalty); overrides
//   load-use stall that cycle. Never asserted while mul_busy (EX held).
//  IRQ: irq rising edge sets irq_pending (held until ack). FSM:
//   IDLE -pending-> DRAIN: stall_if=1, bubble_ex=1; stays while mul_busy or branch_taken
//   DRAIN -> PUSH_PC (irq_push_pc=1, irq_ack=1, clears pending) -> PUSH_FLAGS (irq_push_flags=1)
//   -> VECTOR (irq_load_vec=1, flush_if_id=1) -> IDLE. Each non-DRAIN state is 1 cycle.
//   branch_taken in DRAIN: flush applies, FSM stays DRAIN one extra cycle (branch target is saved PC).
//   irq edge during sequence: sets pending, serviced after return to IDLE.
//  reset mid-sequence or mid-multiply: immediate return to reset state, no strobes.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: perf_stalls += 1 each cycle stall_id=1; perf_flushes += 1 each
//   cycle flush_id_ex=1; both saturate at all-ones. Undefined: both outputs tied to 0, no flops.
// STRUCTURE
//  pipe_ctrl_pkg: fwd_sel_t enum (FWD_RF, FWD_EXMEM, FWD_MEMWB), irq_state_t enum
//   (IRQ_IDLE, IRQ_DRAIN, IRQ_PUSH_PC, IRQ_PUSH_FLAGS, IRQ_VECTOR), MUL_LAT default constant.
//  Sub-module pipe_fwd_sel (comb address compare -> fwd_sel_t), instantiated for src and dst.
// TESTING
//  ex_dst=3,mem_reg_write=1,mem_dst=3,wb_dst=3,wb_reg_write=1,ex_src=3 -> fwd_src=01; mem_reg_write=0 -> 10.
//  ex_mem_read=1,ex_dst=5,id_src=5 used -> stall/bubble exactly 1 cycle; id_src_used=0 -> none.
//  mul in ID, MUL_LAT=4 -> mul_busy 3 cycles, stall_id 3 cycles, then release.
//  branch_taken with load-use same cycle -> flushes only, no stall.
//  irq pulse during mul -> DRAIN until mul done, then PUSH_PC,PUSH_FLAGS,VECTOR one cycle each, irq_ack 1 cycle.
//  reset asserted in PUSH_FLAGS -> next cycle IDLE, no irq_load_vec; PERF build: counters saturate.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the 5-stage pipeline hazard/control unit.
//   fwd_sel_t   : operand bypass select (regfile, EX/MEM result, MEM/WB result)
//   irq_state_t : interrupt-entry sequencer states
//   MUL_LAT_DEF : default number of EX cycles taken by a multiply
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int MUL_LAT_DEF = 4;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef enum logic [2:0] {
        IRQ_IDLE,
        IRQ_DRAIN,
        IRQ_PUSH_PC,
        IRQ_PUSH_FLAGS,
        IRQ_VECTOR
    } irq_state_t;

endpackage

// File: rtl/pipe_fwd_sel.sv
// ---------------------------------------------------------------------------
// pipe_fwd_sel
// Purely combinational bypass selector for one EX operand.
//   op_addr        in  RA_W  register address read by the EX instruction
//   mem_dst        in  RA_W  destination held in the EX/MEM buffer
//   mem_reg_write  in  1     EX/MEM instruction writes the register file
//   wb_dst         in  RA_W  destination held in the MEM/WB buffer
//   wb_reg_write   in  1     MEM/WB instruction writes the register file
//   sel            out 2     fwd_sel_t; EX/MEM wins over MEM/WB (younger value)
// ---------------------------------------------------------------------------
module pipe_fwd_sel
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W = 4
) (
    input  logic [RA_W-1:0] op_addr,
    input  logic [RA_W-1:0] mem_dst,
    input  logic            mem_reg_write,
    input  logic [RA_W-1:0] wb_dst,
    input  logic            wb_reg_write,
    output fwd_sel_t        sel
);

    always_comb begin
        sel = FWD_RF;
        if (mem_reg_write && (mem_dst == op_addr)) begin
            sel = FWD_EXMEM;
        end else if (wb_reg_write && (wb_dst == op_addr)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central hazard/control unit for the 5-stage pipeline: operand forwarding,
// load-use bubbles, multi-cycle multiply stalls, branch flushes and the
// interrupt-entry sequencer.
//   clk, reset                        clock, synchronous active-high reset
//   id_*/ex_*/mem_*/wb_*              pipeline-buffer register addresses/flags
//   branch_taken, irq                 EX branch resolution, level interrupt
//   fwd_src, fwd_dst                  bypass selects for the EX operands
//   stall_if, stall_id, bubble_ex     hold PC / IF-ID, zero ID/EX control
//   flush_if_id, flush_id_ex          squash buffers
//   irq_push_pc/push_flags/load_vec   interrupt sequence strobes, irq_ack
//   mul_busy                          multiply occupying EX
//   perf_stalls, perf_flushes         saturating event counters
// Build option: define PIPE_PERF_CNT_EN to implement the perf counters;
// otherwise they are constant zero and no counter flops exist.
// All combinational outputs are forced to zero while reset is high so that
// a reset landing mid-sequence never emits a stray strobe.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W    = 4,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RA_W-1:0]  id_src,
    input  logic [RA_W-1:0]  id_dst,
    input  logic             id_src_used,
    input  logic             id_dst_used,
    input  logic             id_is_mul,
    input  logic [RA_W-1:0]  ex_src,
    input  logic [RA_W-1:0]  ex_dst,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [RA_W-1:0]  mem_dst,
    input  logic             mem_reg_write,
    input  logic [RA_W-1:0]  wb_dst,
    input  logic             wb_reg_write,
    input  logic             branch_taken,
    input  logic             irq,
    output logic [1:0]       fwd_src,
    output logic [1:0]       fwd_dst,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             irq_push_pc,
    output logic             irq_push_flags,
    output logic             irq_load_vec,
    output logic             irq_ack,
    output logic             mul_busy,
    output logic [CNT_W-1:0] perf_stalls,
    output logic [CNT_W-1:0] perf_flushes
);

    localparam int MC_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

    // ---------------- forwarding: one selector per EX operand -------------
    logic [RA_W-1:0] op_addr [2];
    fwd_sel_t        fwd_sel [2];

    assign op_addr[0] = ex_src;
    assign op_addr[1] = ex_dst;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            pipe_fwd_sel #(.RA_W(RA_W)) u_fwd_sel (
                .op_addr       (op_addr[gi]),
                .mem_dst       (mem_dst),
                .mem_reg_write (mem_reg_write),
                .wb_dst        (wb_dst),
                .wb_reg_write  (wb_reg_write),
                .sel           (fwd_sel[gi])
            );
        end
    endgenerate

    assign fwd_src = reset ? FWD_RF : fwd_sel[0];
    assign fwd_dst = reset ? FWD_RF : fwd_sel[1];

    // ---------------- state ----------------------------------------------
    logic [MC_W-1:0] mul_cnt_reg, mul_cnt_next;
    irq_state_t      irq_state_reg, irq_state_next;
    logic            irq_prev_reg;
    logic            irq_pending_reg, irq_pending_next;

    logic mul_active;
    logic load_use;
    logic branch_flush;
    logic irq_edge;

    assign mul_active   = (mul_cnt_reg != '0);
    assign mul_busy     = mul_active && !reset;
    assign load_use     = ex_mem_read && ex_reg_write &&
                          ((id_src_used && (id_src == ex_dst)) ||
                           (id_dst_used && (id_dst == ex_dst)));
    // EX is frozen while a multiply runs, so a branch cannot resolve then.
    assign branch_flush = branch_taken && !mul_active;
    assign irq_edge     = irq && !irq_prev_reg;

    // ---------------- hazard outputs and interrupt sequencer --------------
    always_comb begin
        stall_if       = 1'b0;
        stall_id       = 1'b0;
        bubble_ex      = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        irq_push_pc    = 1'b0;
        irq_push_flags = 1'b0;
        irq_load_vec   = 1'b0;
        irq_ack        = 1'b0;
        irq_state_next = irq_state_reg;

        // Multiply holds EX in place (no bubble); a taken branch beats load-use.
        if (mul_active) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
        end else if (branch_flush) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end

        case (irq_state_reg)
            IRQ_IDLE: begin
                if (irq_pending_reg) irq_state_next = IRQ_DRAIN;
            end
            IRQ_DRAIN: begin
                stall_if = 1'b1;
                if (!mul_active) bubble_ex = 1'b1;
                // A branch here redirects the PC; wait one more cycle so the
                // pushed PC is the branch target.
                if (!mul_active && !branch_taken) irq_state_next = IRQ_PUSH_PC;
            end
            IRQ_PUSH_PC: begin
                irq_push_pc    = 1'b1;
                irq_ack        = 1'b1;
                irq_state_next = IRQ_PUSH_FLAGS;
            end
            IRQ_PUSH_FLAGS: begin
                irq_push_flags = 1'b1;
                irq_state_next = IRQ_VECTOR;
            end
            IRQ_VECTOR: begin
                irq_load_vec   = 1'b1;
                flush_if_id    = 1'b1;
                irq_state_next = IRQ_IDLE;
            end
            default: irq_state_next = IRQ_IDLE;
        endcase

        if (reset) begin
            stall_if       = 1'b0;
            stall_id       = 1'b0;
            bubble_ex      = 1'b0;
            flush_if_id    = 1'b0;
            flush_id_ex    = 1'b0;
            irq_push_pc    = 1'b0;
            irq_push_flags = 1'b0;
            irq_load_vec   = 1'b0;
            irq_ack        = 1'b0;
        end
    end

    // A multiply starts only when ID actually advances into EX.
    always_comb begin
        mul_cnt_next = mul_cnt_reg;
        if (mul_active) begin
            mul_cnt_next = mul_cnt_reg - MC_W'(1);
        end else if (id_is_mul && !stall_id && !bubble_ex && !flush_id_ex) begin
            mul_cnt_next = MC_W'(MUL_LAT - 1);
        end
    end

    // A new edge wins over the ack so a request arriving mid-sequence is kept.
    always_comb begin
        irq_pending_next = irq_pending_reg;
        if (irq_edge)     irq_pending_next = 1'b1;
        else if (irq_ack) irq_pending_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mul_cnt_reg     <= '0;
            irq_state_reg   <= IRQ_IDLE;
            irq_prev_reg    <= 1'b0;
            irq_pending_reg <= 1'b0;
        end else begin
            mul_cnt_reg     <= mul_cnt_next;
            irq_state_reg   <= irq_state_next;
            irq_prev_reg    <= irq;
            irq_pending_reg <= irq_pending_next;
        end
    end

    // ---------------- optional saturating event counters ------------------
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stalls_reg;
    logic [CNT_W-1:0] perf_flushes_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stalls_reg  <= '0;
            perf_flushes_reg <= '0;
        end else begin
            if (stall_id && (perf_stalls_reg != '1))
                perf_stalls_reg <= perf_stalls_reg + CNT_W'(1);
            if (flush_id_ex && (perf_flushes_reg != '1))
                perf_flushes_reg <= perf_flushes_reg + CNT_W'(1);
        end
    end

    assign perf_stalls  = perf_stalls_reg;
    assign perf_flushes = perf_flushes_reg;
`else
    assign perf_stalls  = '0;
    assign perf_flushes = '0;
`endif

endmodule
